// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and optional call stack for the ROM-fed core.
// Latency: the word at pc is in IR one enabled edge later; a taken branch inserts one bubble.
// Backpressure: en=0 freezes every register; there is no other stall source.
//
// Ports:
//   clk, rst (sync, active high), en   - clock, reset, advance enable
//   rom_addr / rom_data                - combinational ROM read, rom_addr == pc
//   acu_zero                           - accumulator-zero flag for the instruction in IR (JMA)
//   opcode / operand / instr_valid     - IR contents presented to the execute datapath
//   stack_err                          - sticky call-stack overflow/underflow flag
// Build option: define CALL_STACK_EN to instantiate the call stack (CLL/RET);
// without it CLL/RET fall through as NOP and stack_err is tied low.

module fetch_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_WIDTH  = 24,
  parameter int OPER_BITS   = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  output logic [ADDR_BITS-1:0]            rom_addr,
  input  logic [WORD_WIDTH-1:0]           rom_data,
  input  logic                            acu_zero,
  output logic [WORD_WIDTH-OPER_BITS-1:0] opcode,
  output logic [OPER_BITS-1:0]            operand,
  output logic                            instr_valid,
  output logic                            stack_err
);

  localparam int OPC_BITS = WORD_WIDTH - OPER_BITS;

  // Opcode encodings shared with the instruction set definitions.
  localparam logic [OPC_BITS-1:0] OP_JMP = OPC_BITS'(8'h10);
  localparam logic [OPC_BITS-1:0] OP_JMA = OPC_BITS'(8'h11);
  localparam logic [OPC_BITS-1:0] OP_RST = OPC_BITS'(8'h14);

  logic [ADDR_BITS-1:0] pc;
  logic [ADDR_BITS-1:0] pc_next;
  logic [ADDR_BITS-1:0] target;
  logic [ADDR_BITS-1:0] ret_addr;
  logic                 is_jmp;
  logic                 is_jma_taken;
  logic                 is_rst;
  logic                 is_cll;
  logic                 is_ret;
  logic                 taken;

  assign rom_addr = pc;
  // Only the low address bits of the operand form a branch target.
  assign target   = operand[ADDR_BITS-1:0];

  assign is_jmp       = instr_valid && (opcode == OP_JMP);
  assign is_jma_taken = instr_valid && (opcode == OP_JMA) && !acu_zero;
  assign is_rst       = instr_valid && (opcode == OP_RST);
  assign taken        = is_jmp || is_jma_taken || is_rst || is_cll || is_ret;

  always_comb begin
    pc_next = pc + ADDR_BITS'(1);
    if (is_rst) begin
      pc_next = '0;
    end else if (is_ret) begin
      pc_next = ret_addr;
    end else if (taken) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      opcode      <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
    end else if (en) begin
      pc <= pc_next;
      if (taken) begin
        // The word fetched behind a taken branch is squashed; IR keeps the branch.
        instr_valid <= 1'b0;
      end else begin
        opcode      <= rom_data[WORD_WIDTH-1:OPER_BITS];
        operand     <= rom_data[OPER_BITS-1:0];
        instr_valid <= 1'b1;
      end
    end
  end

`ifdef CALL_STACK_EN
  localparam logic [OPC_BITS-1:0] OP_CLL = OPC_BITS'(8'h12);
  localparam logic [OPC_BITS-1:0] OP_RET = OPC_BITS'(8'h13);
  localparam int IDX_BITS = $clog2(STACK_DEPTH);
  localparam int SP_BITS  = IDX_BITS + 1;
  localparam logic [SP_BITS-1:0] SP_FULL = SP_BITS'(STACK_DEPTH);

  // sp counts occupied entries (0..STACK_DEPTH); the top entry is stack[sp-1].
  logic [SP_BITS-1:0]   sp;
  logic [SP_BITS-1:0]   sp_dec;
  logic [ADDR_BITS-1:0] stack [STACK_DEPTH];

  assign is_cll   = instr_valid && (opcode == OP_CLL);
  assign is_ret   = instr_valid && (opcode == OP_RET);
  assign sp_dec   = sp - SP_BITS'(1);
  // An underflowing RET restarts the program at address 0.
  assign ret_addr = (sp == '0) ? '0 : stack[sp_dec[IDX_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (en) begin
      if (is_rst) begin
        sp <= '0;
      end else if (is_cll) begin
        // A full stack drops the push but the call itself still jumps.
        if (sp == SP_FULL) begin
          stack_err <= 1'b1;
        end else begin
          sp <= sp + SP_BITS'(1);
        end
      end else if (is_ret) begin
        if (sp == '0) begin
          stack_err <= 1'b1;
        end else begin
          sp <= sp_dec;
        end
      end
    end
  end

  // pc already points past the CLL, so it is the return address.
  always_ff @(posedge clk) begin
    if (!rst && en && is_cll && (sp != SP_FULL)) begin
      stack[sp[IDX_BITS-1:0]] <= pc;
    end
  end
`else
  assign is_cll    = 1'b0;
  assign is_ret    = 1'b0;
  assign ret_addr  = '0;
  assign stack_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage. It sits directly downstream of the program ROM (24-bit words, 8-bit address, combinational read) and upstream of the execute datapath. It owns the program counter, instruction register, and hardware call stack. It drives the ROM address, latches each word as {opcode, operand}, and resolves JMP/JMA/CLL/RET/RST itself. JMA resolves from the accumulator-zero flag.

## Interface
Parameters:
- ADDR_BITS, 8, program address width (matches ROM RAM_ADDR_BITS)
- WORD_WIDTH, 24, instruction word width (matches ROM RAM_WORD_WIDTH)
- OPER_BITS, 16, operand field width; opcode is upper WORD_WIDTH-OPER_BITS = 8 bits
- STACK_DEPTH, 4, call stack entries (power of two)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance enable; 0 freezes all state
- rom_addr  out  ADDR_BITS  ROM address, equals pc
- rom_data  in  WORD_WIDTH  ROM word at rom_addr, same cycle
- acu_zero  in  1  1 when accumulator == 0, valid for the instruction currently in IR
- opcode  out  8  IR[23:16]
- operand  out  OPER_BITS  IR[15:0]
- instr_valid  out  1  IR holds an instruction the datapath must execute
- stack_err  out  1  sticky call-stack overflow/underflow flag

Opcode encodings come from the `define names in src/control/instructions.v (`NOP, `JMP, `JMA, `CLL, `RET, `RST, ...).

## Operation
- Two-stage pipeline. Fetch presents pc on rom_addr. Execute presents IR on opcode/operand.
- A control-flow instruction is "taken" when instr_valid=1 and it is one of the following:
  - JMP
  - JMA with acu_zero=0
  - CLL
  - RET
  - RST
- Target address = operand[ADDR_BITS-1:0], upper operand bits are ignored.
- Each cycle with en=1:
  - Taken instruction in IR: pc <= target, and the word currently on rom_data is discarded. instr_valid <= 0 (one bubble). IR is unchanged.
  - Otherwise: IR <= rom_data, instr_valid <= 1, pc <= pc+1 modulo 2^ADDR_BITS (255 wraps to 0).
- CLL: push pc (already CLL address+1), sp <= sp+1, pc <= target.
  - If sp == STACK_DEPTH, the push is dropped and stack_err <= 1, but the jump still occurs.
- RET: pc <= stack[sp-1], sp <= sp-1.
  - If sp == 0, pc <= 0 and stack_err <= 1.
- RST: pc <= 0, sp <= 0. The stack contents do not matter. stack_err is unchanged.
- JMA with acu_zero=1 is not taken: it behaves as NOP and the pipeline advances normally.
- Control-flow instructions are still presented to the datapath with instr_valid=1, which must treat them as NOP.
- en=0: pc, IR, instr_valid, sp, stack and stack_err all hold. Outputs are stable.
- Reset values: pc=0, rom_addr=0, IR=0 (opcode=0, operand=0), instr_valid=0, sp=0, stack_err=0.
- rst has priority over en.

## Timing
- Fetch latency: the word at address A appears on opcode/operand one enabled edge after pc==A.
- After reset release, the first enabled edge loads mem[0] with instr_valid=1. pc becomes 1.
- Taken branch: 1 bubble cycle (instr_valid=0). The target instruction is valid 2 enabled edges after the branch entered IR.
- Not-taken JMA: 0 penalty.
- acu_zero is sampled combinationally on the edge that ends the JMA's execute cycle. The datapath must reflect the preceding instruction's result by then.
- Back-to-back taken branches cannot occur, because a bubble always separates them.
- rst asserted mid-operation: the next edge forces reset values regardless of IR contents or en.

## Configuration
- CALL_STACK_EN defined: call stack is instantiated. CLL and RET behave as above, and stack_err is functional.
- CALL_STACK_EN undefined:
  - No stack storage or sp.
  - CLL and RET are never taken: they behave as NOP and the pipeline advances.
  - stack_err is tied to 0.
  - JMP, JMA and RST are unaffected.

## Test plan
- Linear fetch: ROM mem[0..3]={NOP,LDI 5,ST 1,NOP}, en=1 after reset -> opcode sequence NOP,LDI,ST,NOP on consecutive edges with instr_valid=1; rom_addr 1,2,3,4.
- Jump/bubble: mem[2]={JMP 9} -> one cycle with instr_valid=0 after JMP, then mem[9] in IR, rom_addr=10 next.
- JMA loop: mem[8]={JMA 6}, acu_zero=0 -> fetch resumes at 6 with 1 bubble. The same JMA with acu_zero=1 -> mem[9] follows immediately, no bubble.
- Call/return: mem[1]={CLL 20}, mem[25]={RET} -> after RET, IR=mem[2]. Nesting 4 deep returns correctly. A 5th nested CLL -> stack_err=1, jump still taken. With the macro undefined, CLL falls through to mem[2].
- Underflow/RST: RET with empty stack -> pc=0, stack_err=1. A later RST -> pc=0, stack_err stays 1. Only rst clears it.
- Stall and reset: en=0 for 3 cycles mid-program -> all outputs frozen. rst during a pending JMP -> pc=0, instr_valid=0, jump discarded.
